// File: rtl/int_ctrl.sv
// int_ctrl: six-source interrupt controller feeding the CP0 IP field.
// Raw lines are synchronized, captured into PEND (edge or level per bit),
// qualified by MASK and arbitrated with fixed priority (highest index wins).
// A three-state FSM presents one request at a time and tracks it through
// acknowledge and end-of-interrupt.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no request outstanding; arbitrate whenever something is eligible
// REQ     | hwint shows onehot(sel); waiting for irq_ack or a withdraw
// SERVICE | CP0 took the interrupt; CUR valid; waiting for an EOI write
//
// Register map (addr): 0=PEND (W1C on edge bits), 1=MASK, 2=MODE,
// 3=CUR (read-only; any write while in SERVICE is the EOI).

module int_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  src,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [5:0]  hwint,
    input  logic        irq_ack,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] A_PEND = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_MODE = 2'd2;
    localparam logic [1:0] A_CUR  = 2'd3;
    localparam logic [5:0] ONE6   = 6'd1;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [5:0]  r_s1;
    logic [5:0]  r_s2;
    logic [5:0]  r_s3;
    logic [5:0]  r_pend;
    logic [5:0]  r_mask;
    logic [5:0]  r_mode;
    logic [3:0]  r_cur;
    logic [2:0]  r_sel;
    logic [5:0]  r_hwint;

    logic [5:0]  w_edge;
    logic [5:0]  w_w1c;
    logic        w_eoi;
    logic [5:0]  w_eoi_clr;
    logic [5:0]  w_clr;
    logic [5:0]  w_pend_nxt;
    logic [5:0]  w_elig;
    logic        w_any;
    logic [2:0]  w_win;
    logic [5:0]  w_sel_oh;
    logic        w_sel_elig;
    logic        w_sel_load;
    logic [3:0]  w_cur_nxt;
    logic [5:0]  w_hwint_nxt;
    logic        w_unused_wdata;

    // Only the low six data bits carry register content.
    assign w_unused_wdata = ^wdata[31:6];

    // Per-bit edge detect on the synchronized line against its history.
    assign w_edge = r_s2 & ~r_s3;

    // Clear sources: software W1C on PEND, and the EOI of the id in service.
    assign w_w1c     = (we && (addr == A_PEND)) ? wdata[5:0] : 6'd0;
    assign w_eoi     = we && (addr == A_CUR) && (r_state == SERVICE);
    assign w_sel_oh  = ONE6 << r_sel;
    assign w_eoi_clr = w_eoi ? w_sel_oh : 6'd0;
    assign w_clr     = w_w1c | w_eoi_clr;

    // Edge bits: sticky, a fresh edge beats a same-cycle clear.
    // Level bits: follow the synchronized line, clears have no effect.
    assign w_pend_nxt = (r_mode & ((r_pend & ~w_clr) | w_edge))
                      | (~r_mode & r_s2);

    assign w_elig     = r_pend & r_mask;
    assign w_any      = |w_elig;
    assign w_sel_elig = |(w_elig & w_sel_oh);

    // Fixed-priority encoder: the highest eligible index wins.
    always_comb begin
        w_win = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (w_elig[i]) begin
                w_win = i[2:0];
            end
        end
    end

    // Three-flop synchronizer/history chain for the raw source lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 6'd0;
            r_s2 <= 6'd0;
            r_s3 <= 6'd0;
        end else begin
            r_s1 <= src;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Pending capture plus the software-writable MASK and MODE registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 6'd0;
            r_mask <= 6'h3F;
            r_mode <= 6'd0;
        end else begin
            r_pend <= w_pend_nxt;
            if (we && (addr == A_MASK)) begin
                r_mask <= wdata[5:0];
            end
            if (we && (addr == A_MODE)) begin
                r_mode <= wdata[5:0];
            end
        end
    end

    // FSM state register together with the registered request, sel and CUR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sel   <= 3'd0;
            r_cur   <= 4'd0;
            r_hwint <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_hwint <= w_hwint_nxt;
            if (w_sel_load) begin
                r_sel <= w_win;
            end
        end
    end

    // Next-state and registered-output decode. hwint is computed from the
    // next state so it lines up with the state it describes.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_load  = 1'b0;
        w_cur_nxt   = r_cur;
        w_hwint_nxt = 6'd0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = REQ;
                    w_sel_load  = 1'b1;
                    w_hwint_nxt = ONE6 << w_win;
                end
            end
            REQ: begin
                // An acknowledge beats a simultaneous withdraw.
                if (irq_ack) begin
                    w_state_nxt = SERVICE;
                    w_cur_nxt   = {1'b1, r_sel};
                end else if (!w_sel_elig) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_hwint_nxt = w_sel_oh;
                end
            end
            SERVICE: begin
                if (w_eoi) begin
                    w_state_nxt = IDLE;
                    w_cur_nxt   = {1'b0, r_cur[2:0]};
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Combinational register read; unused upper bits read as zero.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            A_PEND:  rdata = {26'd0, r_pend};
            A_MASK:  rdata = {26'd0, r_mask};
            A_MODE:  rdata = {26'd0, r_mode};
            A_CUR:   rdata = {28'd0, r_cur};
            default: rdata = 32'd0;
        endcase
    end

    assign hwint = r_hwint;
    assign busy  = (r_state == SERVICE);

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl. Inputs change 1 ns after a rising edge
// and outputs are sampled there too. Expected hwint values are queued when
// the stimulus is applied and popped when the request shows up.

module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  src;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [5:0]  hwint;
    logic        irq_ack;
    logic        busy;

    int          n_cmp;
    int          n_fail;
    logic [5:0]  exp_q[$];
    logic [5:0]  exp_v;
    logic [31:0] rd;
    bit          ok;

    int_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .src     (src),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .hwint   (hwint),
        .irq_ack (irq_ack),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        wdata = 32'd0;
    endtask

    task automatic pulse_src(input logic [5:0] v);
        src = v;
        tick();
        src = 6'd0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic wait_hwint(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (hwint != 6'd0) begin
                found = 1'b1;
                return;
            end
            tick();
        end
        if (hwint != 6'd0) found = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        read_reg(2'd0, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_pend got %h want %h", rd, 32'h0); end
        read_reg(2'd1, rd);
        n_cmp++; if (rd !== 32'h3F) begin n_fail++; $display("FAIL rst_mask got %h want %h", rd, 32'h3F); end
        read_reg(2'd2, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_mode got %h want %h", rd, 32'h0); end
        read_reg(2'd3, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_cur got %h want %h", rd, 32'h0); end
        n_cmp++; if (hwint !== 6'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_out got hwint=%h busy=%b want 00/0", hwint, busy); end
    endtask

    task automatic test_edge_latency();
        write_reg(2'd2, 32'h3F);
        src = 6'h04;
        tick();                       // edge k
        src = 6'h00;
        exp_q.push_back(6'h04);
        tick();                       // k+1
        tick();                       // k+2
        read_reg(2'd0, rd);
        n_cmp++; if (rd !== 32'h4) begin n_fail++; $display("FAIL lat_pend_k2 got %h want %h", rd, 32'h4); end
        n_cmp++; if (hwint !== 6'h0) begin n_fail++; $display("FAIL lat_hwint_k2 got %h want %h", hwint, 6'h0); end
        tick();                       // k+3
        exp_v = exp_q.pop_front();
        n_cmp++; if (hwint !== exp_v) begin n_fail++; $display("FAIL lat_hwint_k3 got %h want %h", hwint, exp_v); end
        ack();
        read_reg(2'd3, rd);
        n_cmp++; if (rd !== 32'hA || busy !== 1'b1 || hwint !== 6'h0) begin n_fail++; $display("FAIL lat_ack got cur=%h busy=%b hwint=%h want A/1/00", rd, busy, hwint); end
        write_reg(2'd3, 32'h0);
        read_reg(2'd0, rd);
        n_cmp++; if (rd !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL lat_eoi got pend=%h busy=%b want 0/0", rd, busy); end
        read_reg(2'd3, rd);
        n_cmp++; if (rd[3] !== 1'b0) begin n_fail++; $display("FAIL lat_eoi_cur got valid=%b want 0", rd[3]); end
    endtask

    task automatic test_priority();
        pulse_src(6'h12);
        exp_q.push_back(6'h10);
        wait_hwint(10, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || hwint !== exp_v) begin n_fail++; $display("FAIL prio_hwint got %h want %h", hwint, exp_v); end
        read_reg(2'd0, rd);
        n_cmp++; if (rd !== 32'h12) begin n_fail++; $display("FAIL prio_pend got %h want %h", rd, 32'h12); end
        ack();
        read_reg(2'd3, rd);
        n_cmp++; if (rd !== 32'hC) begin n_fail++; $display("FAIL prio_cur got %h want %h", rd, 32'hC); end
        write_reg(2'd3, 32'h0);
        exp_q.push_back(6'h02);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_eoi_busy got %b want 0", busy); end
        tick();
        exp_v = exp_q.pop_front();
        n_cmp++; if (hwint !== exp_v) begin n_fail++; $display("FAIL prio_second got %h want %h", hwint, exp_v); end
        ack();
        write_reg(2'd3, 32'h0);
        read_reg(2'd0, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL prio_drain got %h want %h", rd, 32'h0); end
    endtask

    task automatic test_no_rearb();
        pulse_src(6'h02);
        exp_q.push_back(6'h02);
        wait_hwint(10, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || hwint !== exp_v) begin n_fail++; $display("FAIL hold_first got %h want %h", hwint, exp_v); end
        pulse_src(6'h20);
        for (int i = 0; i < 4; i++) tick();
        read_reg(2'd0, rd);
        n_cmp++; if (hwint !== 6'h02 || rd !== 32'h22) begin n_fail++; $display("FAIL hold_stable got hwint=%h pend=%h want 02/22", hwint, rd); end
        write_reg(2'd3, 32'h0);       // EOI while in REQ is ignored
        read_reg(2'd0, rd);
        n_cmp++; if (hwint !== 6'h02 || busy !== 1'b0 || rd !== 32'h22) begin n_fail++; $display("FAIL eoi_in_req got hwint=%h busy=%b pend=%h want 02/0/22", hwint, busy, rd); end
        ack();
        read_reg(2'd3, rd);
        n_cmp++; if (rd !== 32'h9) begin n_fail++; $display("FAIL hold_cur got %h want %h", rd, 32'h9); end
        write_reg(2'd3, 32'h0);
        exp_q.push_back(6'h20);
        tick();
        exp_v = exp_q.pop_front();
        n_cmp++; if (hwint !== exp_v) begin n_fail++; $display("FAIL hold_next got %h want %h", hwint, exp_v); end
        ack();
        write_reg(2'd3, 32'h0);
        ack();                        // ack while IDLE is ignored
        n_cmp++; if (busy !== 1'b0 || hwint !== 6'h0) begin n_fail++; $display("FAIL ack_in_idle got busy=%b hwint=%h want 0/00", busy, hwint); end
    endtask

    task automatic test_level_withdraw();
        write_reg(2'd2, 32'h0);
        src = 6'h01;
        exp_q.push_back(6'h01);
        wait_hwint(10, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || hwint !== exp_v) begin n_fail++; $display("FAIL lvl_req got %h want %h", hwint, exp_v); end
        write_reg(2'd0, 32'h1);       // W1C has no effect on a level bit
        read_reg(2'd0, rd);
        n_cmp++; if (rd !== 32'h1) begin n_fail++; $display("FAIL lvl_w1c got %h want %h", rd, 32'h1); end
        src = 6'h00;
        tick();
        tick();
        tick();
        read_reg(2'd0, rd);
        n_cmp++; if (rd !== 32'h0 || hwint !== 6'h01) begin n_fail++; $display("FAIL lvl_drop got pend=%h hwint=%h want 0/01", rd, hwint); end
        tick();
        n_cmp++; if (hwint !== 6'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL lvl_withdraw got hwint=%h busy=%b want 00/0", hwint, busy); end
    endtask

    task automatic test_mask();
        write_reg(2'd2, 32'h3F);
        write_reg(2'd1, 32'h0);
        pulse_src(6'h08);
        for (int i = 0; i < 4; i++) tick();
        read_reg(2'd0, rd);
        n_cmp++; if (rd !== 32'h8 || hwint !== 6'h0) begin n_fail++; $display("FAIL mask_off got pend=%h hwint=%h want 8/00", rd, hwint); end
        write_reg(2'd1, 32'hFFFFFF08);
        read_reg(2'd1, rd);
        n_cmp++; if (rd !== 32'h8 || hwint !== 6'h0) begin n_fail++; $display("FAIL mask_wr got mask=%h hwint=%h want 8/00", rd, hwint); end
        exp_q.push_back(6'h08);
        tick();
        exp_v = exp_q.pop_front();
        n_cmp++; if (hwint !== exp_v) begin n_fail++; $display("FAIL mask_on got %h want %h", hwint, exp_v); end
        ack();
        write_reg(2'd3, 32'h0);
        write_reg(2'd1, 32'h0);
        pulse_src(6'h08);
        for (int i = 0; i < 4; i++) tick();
        write_reg(2'd0, 32'hFFFFFF08);
        read_reg(2'd0, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL w1c_edge got %h want %h", rd, 32'h0); end
        write_reg(2'd1, 32'h3F);
    endtask

    task automatic test_refire();
        pulse_src(6'h20);
        exp_q.push_back(6'h20);
        wait_hwint(10, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || hwint !== exp_v) begin n_fail++; $display("FAIL refire_first got %h want %h", hwint, exp_v); end
        ack();
        pulse_src(6'h20);             // edge k
        tick();                       // k+1
        write_reg(2'd3, 32'h0);       // EOI on k+2, same cycle as the new edge
        read_reg(2'd0, rd);
        n_cmp++; if (rd !== 32'h20 || busy !== 1'b0) begin n_fail++; $display("FAIL refire_pend got pend=%h busy=%b want 20/0", rd, busy); end
        exp_q.push_back(6'h20);
        tick();
        exp_v = exp_q.pop_front();
        n_cmp++; if (hwint !== exp_v) begin n_fail++; $display("FAIL refire_req got %h want %h", hwint, exp_v); end
        ack();
        write_reg(2'd3, 32'h0);
        read_reg(2'd0, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL refire_drain got %h want %h", rd, 32'h0); end
    endtask

    task automatic test_reset_service();
        write_reg(2'd1, 32'h04);
        pulse_src(6'h04);
        exp_q.push_back(6'h04);
        wait_hwint(10, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || hwint !== exp_v) begin n_fail++; $display("FAIL rsvc_req got %h want %h", hwint, exp_v); end
        ack();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rsvc_busy got %b want 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        read_reg(2'd0, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rsvc_pend got %h want %h", rd, 32'h0); end
        read_reg(2'd3, rd);
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rsvc_cur got %h want %h", rd, 32'h0); end
        read_reg(2'd1, rd);
        n_cmp++; if (rd !== 32'h3F) begin n_fail++; $display("FAIL rsvc_mask got %h want %h", rd, 32'h3F); end
        n_cmp++; if (hwint !== 6'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rsvc_out got hwint=%h busy=%b want 00/0", hwint, busy); end
        write_reg(2'd2, 32'h3F);
        pulse_src(6'h02);
        exp_q.push_back(6'h02);
        wait_hwint(10, ok);
        exp_v = exp_q.pop_front();
        n_cmp++; if (!ok || hwint !== exp_v) begin n_fail++; $display("FAIL rsvc_after got %h want %h", hwint, exp_v); end
        ack();
        write_reg(2'd3, 32'h0);
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst     = 1'b1;
        src     = 6'd0;
        addr    = 2'd0;
        we      = 1'b0;
        wdata   = 32'd0;
        irq_ack = 1'b0;
        test_reset();
        test_edge_latency();
        test_priority();
        test_no_rearb();
        test_level_withdraw();
        test_mask();
        test_refire();
        test_reset_service();
        n_cmp++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL sb_leftover got %0d want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
